// File: rtl/encoder_mem_rd_arbiter_if.sv
// ----------------------------------------------------------------------------
// encoder_mem_rd_arbiter_if
//
// Purpose: bundles the encoder's external memory read port so the arbiter
// and the memory (or a testbench standing in for it) connect with one port.
//
// Signals:
//   mem_rd_en     request valid, driven by the arbiter (master)
//   mem_rd_addr   request address, driven by the arbiter
//   mem_rd_ready  memory accepts the request this cycle
//   mem_rd_data   returned read data
//   mem_rd_valid  read data beat, returned in issue order
//
// Modports: master = arbiter side, slave = memory side.
// ----------------------------------------------------------------------------
interface encoder_mem_rd_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int BUS_WIDTH  = 512
);
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic                  mem_rd_ready;
    logic [BUS_WIDTH-1:0]  mem_rd_data;
    logic                  mem_rd_valid;

    modport master (
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_ready,
        input  mem_rd_data,
        input  mem_rd_valid
    );

    modport slave (
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_ready,
        output mem_rd_data,
        output mem_rd_valid
    );
endinterface

// File: rtl/encoder_mem_rd_arbiter.sv
// ----------------------------------------------------------------------------
// encoder_mem_rd_arbiter
//
// Purpose: shares the encoder's single memory read port among NUM_REQ
// requesters (0 = tokenizer, 1 = embedding lookup, 2 = transformer layer).
// The granted request is registered onto the memory port, its requester ID is
// pushed into an in-order ID FIFO, and each returning read beat is routed back
// to the requester at the FIFO head.
//
// Configuration macro: ENC_ARB_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration, search starts after the last grant
//   undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_en          per-requester read request, held until accepted
//   req_addr        per-requester read address
//   req_ready       one-hot grant (combinational)
//   rsp_valid       one-hot response strobe (registered)
//   rsp_data        response data, broadcast to all requesters (registered)
//   outstanding     ID FIFO occupancy
//   err_unexpected  sticky: a read beat arrived with no outstanding request
//   mem             memory read port (master modport)
//
// MAX_OUTSTANDING must be a power of two and at least 2.
// ----------------------------------------------------------------------------
module encoder_mem_rd_arbiter #(
    parameter int NUM_REQ         = 3,
    parameter int BUS_WIDTH       = 512,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_en,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [BUS_WIDTH-1:0]                rsp_data,
    output logic [$clog2(MAX_OUTSTANDING):0]    outstanding,
    output logic                                err_unexpected,
    encoder_mem_rd_arbiter_if.master            mem
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0]      id_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic                  mem_rd_en_q;
    logic [ADDR_WIDTH-1:0] mem_rd_addr_q;
    logic                  slot_free;
    logic                  grant_found;
    logic [IDX_W-1:0]      grant_idx;
    logic                  accept;
    logic                  pop;

    assign mem.mem_rd_en   = mem_rd_en_q;
    assign mem.mem_rd_addr = mem_rd_addr_q;

    // Occupancy is the pre-pop value, so a full FIFO blocks a grant even in
    // a cycle where a response frees an entry.
    assign slot_free = (!mem_rd_en_q || mem.mem_rd_ready) &&
                       (outstanding < CNT_W'(MAX_OUTSTANDING));
    assign accept    = slot_free && grant_found;
    assign pop       = mem.mem_rd_valid && (outstanding != '0);

`ifdef ENC_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] cand;

    // Walk the candidates from farthest to nearest after 'last' so the
    // nearest requesting index is the final one written.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = IDX_W'((int'(last) + off) % NUM_REQ);
            if (req_en[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= IDX_W'(NUM_REQ - 1);
        end else if (accept) begin
            last <= grant_idx;
        end
    end
`else
    // Fixed priority: descending scan leaves the lowest requesting index.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_en[i]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // ID storage needs no reset; only entries between head and tail matter.
    always_ff @(posedge clk) begin
        if (accept) begin
            id_fifo[tail] <= grant_idx;
        end
    end

    // The memory request register holds under backpressure and drops once
    // the memory has taken the request and nothing new was granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd_en_q    <= 1'b0;
            mem_rd_addr_q  <= '0;
            head           <= '0;
            tail           <= '0;
            outstanding    <= '0;
            rsp_valid      <= '0;
            rsp_data       <= '0;
            err_unexpected <= 1'b0;
        end else begin
            if (accept) begin
                mem_rd_en_q   <= 1'b1;
                mem_rd_addr_q <= req_addr[grant_idx];
                tail          <= tail + 1'b1;
            end else if (mem.mem_rd_ready) begin
                mem_rd_en_q <= 1'b0;
            end

            if (pop) begin
                head <= head + 1'b1;
            end

            case ({accept, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            rsp_valid <= pop ? (NUM_REQ'(1) << id_fifo[head]) : '0;
            if (pop) begin
                rsp_data <= mem.mem_rd_data;
            end

            // A beat with nothing outstanding is dropped and flagged.
            if (mem.mem_rd_valid && (outstanding == '0)) begin
                err_unexpected <= 1'b1;
            end
        end
    end

endmodule

// File: doc/encoder_mem_rd_arbiter.md
# encoder_mem_rd_arbiter

- Shares the encoder's single memory read port among `NUM_REQ` requesters (tokenizer = 0, embedding lookup = 1, transformer layer = 2).
- Registers the issued request and tracks outstanding reads in an in-order ID FIFO.
- Routes each returning `mem_rd_valid` beat back to the requester that issued it.
- Sits between the encoder sub-blocks and the encoder's external `mem_rd_*` interface, replacing a purely combinational priority mux.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesters (≥2).
- `BUS_WIDTH`, 512: read data width.
- `ADDR_WIDTH`, 32: address width.
- `MAX_OUTSTANDING`, 8: ID FIFO depth; must be a power of two.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req_en` in `[NUM_REQ-1:0]`: per-requester read request. Held until accepted.
- `req_addr` in `[NUM_REQ-1:0][ADDR_WIDTH-1:0]`: per-requester address. Stable while `req_en` is high.
- `req_ready` out `[NUM_REQ-1:0]`: one-hot grant. Combinational. Accept = `req_en[i] & req_ready[i]`.
- `rsp_valid` out `[NUM_REQ-1:0]`: one-hot response strobe. Registered.
- `rsp_data` out `BUS_WIDTH`: response data, broadcast to all requesters. Registered.
- `mem_rd_en` out 1: memory read request. Registered.
- `mem_rd_addr` out `ADDR_WIDTH`: memory read address. Registered.
- `mem_rd_ready` in 1: memory accepts the request this cycle.
- `mem_rd_data` in `BUS_WIDTH`: memory read data.
- `mem_rd_valid` in 1: read data beat, returned in issue order.
- `outstanding` out `$clog2(MAX_OUTSTANDING)+1`: current FIFO occupancy.
- `err_unexpected` out 1: sticky flag for a response that arrived with the FIFO empty.

## Operation
- Reset value of every output is 0.
- Issue slot free when `!mem_rd_en || mem_rd_ready` AND `outstanding < MAX_OUTSTANDING`.
- `outstanding` is sampled before any same-cycle pop, so a full FIFO blocks a grant even when a response pops in that cycle.
- Grant is only asserted when the slot is free. At most one `req_ready` bit is high, and it is high only where `req_en` is high.
- On accept:
  - `mem_rd_en<=1` and `mem_rd_addr<=req_addr[g]`.
  - Push ID `g` to the FIFO tail.
- Output register behaviour:
  - Holds its value while `mem_rd_en && !mem_rd_ready`.
  - Clears `mem_rd_en` when `mem_rd_ready` is high and there is no new accept.
- Response routing, on `mem_rd_valid`:
  - If the FIFO is non-empty: pop the head ID `h`, then `rsp_valid<=1<<h` and `rsp_data<=mem_rd_data`.
  - If the FIFO is empty: drop the beat, leave `rsp_valid` at 0, set `err_unexpected<=1`.
- `rsp_valid` is 0 in any cycle without `mem_rd_valid`. `rsp_data` holds its last value.
- Simultaneous push and pop: `outstanding` is unchanged. Head and tail pointers both advance and wrap modulo `MAX_OUTSTANDING`.
- `err_unexpected` is cleared only by reset.
- Reset mid-operation:
  - The FIFO, pointers, output register and round-robin pointer all clear.
  - Beats still in flight in memory from before the reset arrive with the FIFO empty and therefore set `err_unexpected`.
  - Integration is responsible for draining memory before reset.

## Timing
- Request-to-memory latency: 1 cycle. An accept in cycle N gives `mem_rd_en=1` in cycle N+1.
- Response latency: 1 cycle. `mem_rd_valid` in cycle M gives `rsp_valid` in cycle M+1.
- Sustained throughput: one accept per cycle while `mem_rd_ready=1` and the FIFO is not full.
- Grant logic is combinational from `req_en`, the arbitration pointer, `mem_rd_en`, `mem_rd_ready` and `outstanding`.
- Requesters must not make `req_en` depend combinationally on `req_ready`.

## Configuration
- Macro: `ENC_ARB_ROUND_ROBIN_EN`.
- Defined (round-robin):
  - A `$clog2(NUM_REQ)`-bit pointer `last` holds the most recent granted index. Reset value `NUM_REQ-1`.
  - The search starts at `last+1` modulo `NUM_REQ`.
  - `last` updates only on accept.
- Undefined (fixed priority): lowest index wins, i.e. tokenizer > embedding lookup > layer. No pointer is kept.

## Test plan
- Single requester: `req_en=3'b010`, addr `0x1000`, `mem_rd_ready=1`.
  - Expect `req_ready=3'b010` in cycle 0, then `mem_rd_en=1` with addr `0x1000` in cycle 1.
  - Data `0xAB` returned in cycle 4 → `rsp_valid=3'b010` and `rsp_data=0xAB` in cycle 5.
- Contention: all three `req_en` held high for 6 accepts.
  - Round-robin: grant order 0,1,2,0,1,2.
  - Fixed priority: 0 six times.
- Backpressure: `mem_rd_ready=0` for 3 cycles with a request pending. `mem_rd_en` and `mem_rd_addr` hold, `req_ready=0`, and the request issues the cycle after `mem_rd_ready` rises.
- FIFO full and order:
  - Issue 8 reads (IDs 0,1,2,0,1,2,0,1) with no responses → `outstanding=8`, `req_ready=0`.
  - Return 8 beats → `rsp_valid` sequence matches the issue IDs in order.
  - A response in the same cycle as a new request still gives no grant, since occupancy is sampled before the pop.
- Unexpected response: `mem_rd_valid` with the FIFO empty → `rsp_valid=0` and `err_unexpected=1`, held until `rst_n` is asserted.
- Reset mid-flight: assert `rst_n=0` with 3 reads outstanding → all outputs 0, `outstanding=0`, and round-robin restarts at requester 0.
